flt2int_conv: RTL and testbench
===============================

// Module: flt2int_conv
// PURPOSE
//  Multi-cycle FP32 -> 32-bit integer converter for FCVT.W.S / FCVT.WU.S.
//  - Reverse of the combinational int->float path in the FPU; lives beside it in EX.
//  - Stalls the pipeline through busy.
//  - Aligns the mantissa by iterative left shift, then rounds per flt_rm.
//  - Saturates out-of-range inputs and reports RISC-V NV/NX flags.
// PARAMETERS
//  BITS_PER_CYCLE  4  mantissa left-shift distance per SHIFT cycle; legal values 1, 2, 4, 8
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  start        in   1   request; sampled only in IDLE or DONE
//  opa          in   32  FP32 operand; captured on accepted start
//  is_unsigned  in   1   1 = FCVT.WU.S, 0 = FCVT.W.S; captured on accepted start
//  flt_rm       in   3   rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM); captured on start
//  res          out  32  integer result; valid when done=1, held until next done
//  busy         out  1   high in SHIFT and ROUND
//  done         out  1   one-cycle pulse, result and flags valid
//  flag_nv      out  1   invalid; valid with done
//  flag_nx      out  1   inexact; valid with done
// BEHAVIOUR
//  Reset (async): state=IDLE; res=0, busy=0, done=0, flag_nv=0, flag_nx=0.
//  - Reset during SHIFT/ROUND aborts the operation; no done is produced.
//  FSM states: IDLE, SHIFT, ROUND, DONE.
//  - IDLE/DONE + start -> load; go to SHIFT if S>0, else ROUND.
//  - SHIFT -> ROUND after S cycles.
//  - ROUND -> DONE.
//  - DONE -> IDLE, or load again if start=1.
//  - start in SHIFT/ROUND is ignored.
//  Load: e = exp - 127.
//  - Accumulator = {32'h0, 1'b1, m[22:0], 8'h0}, i.e. 32 integer bits and 32 fraction bits.
//  - Normal 0<=e<=31: S = ceil((e+1)/BITS_PER_CYCLE).
//    - Each SHIFT cycle shifts left by min(BITS_PER_CYCLE, bits remaining).
//    - Total shift distance is e+1.
//  - All other classes: S = 0.
//  Rounding inputs after alignment:
//  - Integer = acc[63:32].
//  - guard = acc[31], round = acc[30], sticky = |acc[29:0].
//  - e=-1: integer 0, guard=1, round=m[22], sticky=|m[21:0].
//  - e<=-2, or exp=0 with m!=0: integer 0, guard=0, round=(e==-2), sticky=1.
//  - Zero: exact 0, no flags.
//  round_up rule:
//  - RNE: g&(r|s) | g&~r&~s&lsb.
//  - RTZ: 0.
//  - RDN: (g|r|s)&sign.
//  - RUP: (g|r|s)&~sign.
//  - RMM: g.
//  - rm 101..111: behave as RTZ.
//  Magnitude = integer + round_up, computed 33 bits wide; result = sign ? -magnitude : magnitude.
//  NX = g|r|s whenever NV=0.
//  Range checks (done in ROUND), each sets NV=1 and NX=0:
//  - Signed, magnitude > 2^31-1 with sign=0: res 0x7FFFFFFF.
//  - Signed, magnitude > 2^31 with sign=1: res 0x80000000.
//  - Unsigned, magnitude > 2^32-1: res 0xFFFFFFFF.
//  - Unsigned, sign=1 and magnitude != 0: res 0.
//  - Unsigned, negative input that rounds to 0: res 0, NX per g|r|s, NV=0.
//  Specials, S = 0, NV=1:
//  - NaN or +inf: signed 0x7FFFFFFF, unsigned 0xFFFFFFFF.
//  - -inf: signed 0x80000000, unsigned 0.
//  - Finite e>=32: saturate per the range rules above.
//  Latency: start accepted at edge k; done=1 in the cycle after edge k+S+2; busy=1 for S+1 cycles.
//  res and flags are registered on the ROUND->DONE edge and held until the next ROUND->DONE edge.
// TESTING
//  1. 0x40600000 (3.5), signed.
//     - RNE -> res 4, NX=1.
//     - RTZ -> res 3, NX=1.
//     - RMM -> res 4.
//  2. 0xC0200000 (-2.5), signed.
//     - RNE -> 0xFFFFFFFE (-2).
//     - RDN -> 0xFFFFFFFD (-3).
//     - RUP -> 0xFFFFFFFE.
//     - NX=1 in all three cases.
//  3. Range limits.
//     - 0x4F000000 signed -> 0x7FFFFFFF, NV=1.
//     - 0xCF000000 signed -> 0x80000000, NV=0, NX=0.
//     - 0x4F000000 unsigned -> 0x80000000, no flags.
//  4. NaN and small negative inputs.
//     - 0x7FC00000 signed -> 0x7FFFFFFF, NV=1; unsigned -> 0xFFFFFFFF, NV=1.
//     - 0xBECCCCCD (-0.4) unsigned RTZ -> 0, NX=1, NV=0.
//     - 0xBECCCCCD unsigned RDN -> 0, NV=1, NX=0.
//  5. Timing, BITS_PER_CYCLE=4, input 0x4B7FFFFF (e=23), RNE.
//     - S=6; busy high 7 cycles; done at k+8; res 0x00FFFFFF, no flags.
//     - A second start pulsed mid-op is ignored.
//  6. Reset and back-to-back.
//     - rst asserted during SHIFT -> busy, done, res and flags all 0 immediately; no done follows.
//     - Next start of 0x3F800000 -> res 1, no flags.
//     - start held high in DONE -> back-to-back op accepted.

Source files
------------

// File: rtl/flt2int_conv.sv
// flt2int_conv: multi-cycle FP32 -> int32/uint32 converter (FCVT.W.S / FCVT.WU.S) with RISC-V NV/NX flags
//   clk, rst (async, active-high), start/opa/is_unsigned/flt_rm in; res, busy, done, flag_nv, flag_nx out
module flt2int_conv #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] opa,
  input  logic        is_unsigned,
  input  logic [2:0]  flt_rm,
  output logic [31:0] res,
  output logic        busy,
  output logic        done,
  output logic        flag_nv,
  output logic        flag_nx
);
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
  localparam logic [5:0] BPC = 6'(BITS_PER_CYCLE);
  state_t state, state_nx;
  logic [63:0] acc, ld_acc;
  logic [5:0] cnt, ld_cnt, step;
  logic sign, uns, sat;
  logic [2:0] rm;
  logic [7:0] ex;
  logic [22:0] man;
  logic ld, normal, g, r, s, ru, nv;
  logic [32:0] mag;
  logic [31:0] sat_val, res_d;
  assign ex = opa[30:23];
  assign man = opa[22:0];
  assign ld = start & (state == IDLE || state == DONE);
  assign normal = ex >= 8'd126 && ex <= 8'd158;
  assign ld_cnt = normal ? 6'(ex - 8'd126) : 6'd0;
  // tiny values (|x| < 0.5 or subnormal) collapse to guard=0, round=(e==-2), sticky=1
  assign ld_acc = normal ? {32'h0, 1'b1, man, 8'h0} :
                  (ex == 8'd0 && man == 23'd0) ? 64'h0 :
                  {32'h0, 1'b0, ex == 8'd125, 30'h1};
  assign step = cnt > BPC ? BPC : cnt;
  assign busy = state == SHIFT || state == ROUND;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: state_nx = ld ? (ld_cnt != 6'd0 ? SHIFT : ROUND) : IDLE;
      SHIFT:      state_nx = cnt <= BPC ? ROUND : SHIFT;
      ROUND:      state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  assign g = acc[31];
  assign r = acc[30];
  assign s = |acc[29:0];
  assign ru = flt_rm_sel(rm, g, r, s, acc[32], sign);
  assign mag = {1'b0, acc[63:32]} + 33'(ru);
  // sat covers NaN/inf and e>=32; NaN sign was cleared at load so it saturates positive
  assign nv = sat | (uns ? (mag[32] | (sign & |mag)) :
                     (sign ? mag > 33'h080000000 : mag > 33'h07FFFFFFF));
  assign sat_val = uns ? (sign ? 32'h0 : 32'hFFFFFFFF) : (sign ? 32'h80000000 : 32'h7FFFFFFF);
  assign res_d = nv ? sat_val : (sign ? -mag[31:0] : mag[31:0]);
  function automatic logic flt_rm_sel(input logic [2:0] m, input logic gg, rr, ss, lsb, sg);
    return m == 3'b000 ? gg & (rr | ss | lsb) :
           m == 3'b010 ? (gg | rr | ss) & sg :
           m == 3'b011 ? (gg | rr | ss) & ~sg :
           m == 3'b100 ? gg : 1'b0;
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      sign <= 1'b0;
      uns <= 1'b0;
      sat <= 1'b0;
      rm <= '0;
      res <= '0;
      flag_nv <= 1'b0;
      flag_nx <= 1'b0;
    end else begin
      if (ld) begin
        acc <= ld_acc;
        cnt <= ld_cnt;
        sign <= opa[31] & ~(ex == 8'hFF && man != 23'd0);
        uns <= is_unsigned;
        sat <= ex >= 8'd159;
        rm <= flt_rm;
      end else if (state == SHIFT) begin
        acc <= acc << step;
        cnt <= cnt - step;
      end
      if (state == ROUND) begin
        res <= res_d;
        flag_nv <= nv;
        flag_nx <= ~nv & (g | r | s);
      end
    end
endmodule

// File: tb/tb_flt2int_conv.sv
// tb_flt2int_conv: randomized + directed check of flt2int_conv against an exact-arithmetic reference model
module tb_flt2int_conv;
  localparam int B = 4;
  logic clk = 0, rst, start, is_unsigned, busy, done, flag_nv, flag_nx;
  logic [31:0] opa, res;
  logic [2:0] flt_rm;
  int n_tests = 0, n_fail = 0;
  flt2int_conv #(.BITS_PER_CYCLE(B)) dut (
    .clk(clk), .rst(rst), .start(start), .opa(opa), .is_unsigned(is_unsigned),
    .flt_rm(flt_rm), .res(res), .busy(busy), .done(done), .flag_nv(flag_nv), .flag_nx(flag_nx)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // exact value = (-1)^s * mant * 2^E, rounded by comparing the discarded remainder to one half
  function automatic logic [33:0] model(input logic [31:0] a, input bit u, input logic [2:0] m);
    bit sg, pos, inex, hi, tie, up, nv;
    int ex, e2, sh;
    longint mant, ip, rem, half, mag, v;
    logic [31:0] sv;
    sg = a[31];
    ex = int'(a[30:23]);
    if (ex == 255) begin
      pos = !sg || a[22:0] != 0;
      return {1'b1, 1'b0, u ? (pos ? 32'hFFFFFFFF : 32'h0) : (pos ? 32'h7FFFFFFF : 32'h80000000)};
    end
    mant = ex == 0 ? longint'(a[22:0]) : longint'({1'b1, a[22:0]});
    if (mant == 0) return 34'h0;
    e2 = ex == 0 ? -149 : ex - 150;
    ip = 0; inex = 0; hi = 0; tie = 0;
    if (e2 >= 9) ip = longint'(1) << 34;
    else if (e2 >= 0) ip = mant << e2;
    else if (e2 <= -40) inex = 1;
    else begin
      sh = -e2;
      ip = mant >> sh;
      rem = mant - (ip << sh);
      half = longint'(1) << (sh - 1);
      inex = rem != 0;
      hi = rem > half;
      tie = rem == half;
    end
    up = m == 0 ? (hi | (tie & ip[0])) : m == 2 ? inex & sg : m == 3 ? inex & ~sg : m == 4 ? hi | tie : 1'b0;
    mag = ip + longint'(up);
    v = sg ? -mag : mag;
    nv = u ? (v < 0 || v > 64'sd4294967295) : (v > 64'sd2147483647 || v < -64'sd2147483648);
    sv = u ? (v < 0 ? 32'h0 : 32'hFFFFFFFF) : (v < 0 ? 32'h80000000 : 32'h7FFFFFFF);
    return {nv, inex & ~nv, nv ? sv : v[31:0]};
  endfunction
  function automatic int shifts(input logic [31:0] a);
    int ex;
    ex = int'(a[30:23]);
    return (ex >= 126 && ex <= 158) ? (ex - 126 + B - 1) / B : 0;
  endfunction
  task automatic run(input logic [31:0] a, input bit u, input logic [2:0] m, input bit mid);
    logic [33:0] e;
    int lat, bcnt, sc;
    e = model(a, u, m);
    sc = shifts(a);
    @(negedge clk);
    opa = a; is_unsigned = u; flt_rm = m; start = 1;
    @(negedge clk);
    start = 0; lat = 1; bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      if (mid && lat == 3) begin
        start = 1; opa = 32'h3F800000; is_unsigned = 1; flt_rm = 3'd1;
      end else start = 0;
      @(negedge clk);
      lat++;
    end
    check($sformatf("res %h u%0d rm%0d", a, u, m), 64'(res), 64'(e[31:0]));
    check($sformatf("nv %h u%0d rm%0d", a, u, m), 64'(flag_nv), 64'(e[33]));
    check($sformatf("nx %h u%0d rm%0d", a, u, m), 64'(flag_nx), 64'(e[32]));
    check($sformatf("latency %h", a), 64'(lat), 64'(sc + 2));
    check($sformatf("busy_cycles %h", a), 64'(bcnt), 64'(sc + 1));
  endtask
  initial begin
    int lat;
    bit seen;
    logic [31:0] a;
    rst = 1; start = 0; opa = 0; is_unsigned = 0; flt_rm = 0;
    #12;
    check("reset_out", {27'h0, busy, done, flag_nv, flag_nx, res}, 64'h0);
    @(negedge clk); rst = 0;
    run(32'h40600000, 0, 3'd0, 0);
    check("3.5 rne", 64'(res), 64'd4);
    run(32'h40600000, 0, 3'd1, 0);
    run(32'h40600000, 0, 3'd4, 0);
    run(32'hC0200000, 0, 3'd0, 0);
    check("-2.5 rne", 64'(res), 64'hFFFFFFFE);
    run(32'hC0200000, 0, 3'd2, 0);
    run(32'hC0200000, 0, 3'd3, 0);
    run(32'h4F000000, 0, 3'd0, 0);
    run(32'hCF000000, 0, 3'd0, 0);
    check("min_int", 64'({flag_nv, flag_nx, res}), 64'h080000000);
    run(32'h4F000000, 1, 3'd0, 0);
    run(32'h7FC00000, 0, 3'd0, 0);
    run(32'h7FC00000, 1, 3'd0, 0);
    run(32'hFF800000, 0, 3'd0, 0);
    run(32'hFF800000, 1, 3'd0, 0);
    run(32'hBECCCCCD, 1, 3'd1, 0);
    run(32'hBECCCCCD, 1, 3'd2, 0);
    check("-0.4 rdn u", 64'({flag_nv, flag_nx, res}), 64'h200000000);
    run(32'h80000000, 1, 3'd2, 0);
    run(32'h00000001, 0, 3'd3, 0);
    run(32'h4B7FFFFF, 0, 3'd0, 1);
    check("timing res", 64'(res), 64'h00FFFFFF);
    @(negedge clk);
    check("no_reload", 64'({busy, done}), 64'h0);
    run(32'hC0200000, 0, 3'd2, 0);
    @(negedge clk);
    opa = 32'h4B7FFFFF; is_unsigned = 0; flt_rm = 0; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    check("busy_before_rst", 64'(busy), 64'h1);
    rst = 1;
    #1;
    check("rst_mid_op", {27'h0, busy, done, flag_nv, flag_nx, res}, 64'h0);
    @(negedge clk); rst = 0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen |= done;
    end
    check("no_done_after_rst", 64'(seen), 64'h0);
    run(32'h3F800000, 0, 3'd0, 0);
    check("one", 64'({flag_nv, flag_nx, res}), 64'h1);
    @(negedge clk);
    opa = 32'h40600000; is_unsigned = 0; flt_rm = 0; start = 1;
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("b2b first", 64'(res), 64'd4);
    opa = 32'hC0200000; flt_rm = 3'd1;
    @(negedge clk); start = 0;
    check("b2b accepted", 64'(busy), 64'h1);
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("b2b second", 64'({flag_nv, flag_nx, res}), 64'h1FFFFFFFE);
    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 9);
      a = $urandom;
      if (k < 7) a[30:23] = 8'($urandom_range(100, 165));
      else if (k == 7) a[30:23] = 8'h00;
      else if (k == 8) a[30:23] = 8'hFF;
      run(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
